// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge bus between the MEM-stage access unit
// (master) and the data memory (slave).
interface mem_access_unit_if #(
   parameter int ADDR_W = 32
);
   logic              dmem_req;
   logic              dmem_we;
   logic [3:0]        dmem_be;
   logic [ADDR_W-1:0] dmem_addr;
   logic [31:0]       dmem_wdata;
   logic [31:0]       dmem_rdata;
   logic              dmem_ack;

   modport master (
      output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
      input  dmem_rdata, dmem_ack
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
      output dmem_rdata, dmem_ack
   );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine for the MIPS pipeline. Decodes the EX/MEM
// instruction, issues one request on a variable-latency data-memory bus,
// stalls the pipeline until the access completes, and produces byte enables,
// lane-replicated store data and sign/zero-extended load results.
// Optional feature: define MEM_TIMEOUT_EN to abort a BUSY access that has
// waited TIMEOUT_CYCLES cycles without ack (timeout_exc pulses).
module mem_access_unit #(
   parameter int ADDR_W         = 32,
   parameter bit BIG_ENDIAN     = 1'b1,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       ex_mem_instr,
   input  logic              ex_mem_valid,
   input  logic [ADDR_W-1:0] ex_mem_addr,
   input  logic [31:0]       ex_mem_wdata,
   mem_access_unit_if.master dmem,
   output logic              mem_stall,
   output logic              load_valid,
   output logic [31:0]       load_data,
   output logic [4:0]        load_rt,
   output logic              misalign_exc,
   output logic              timeout_exc
);
   localparam logic [5:0] OP_LB  = 6'd32;
   localparam logic [5:0] OP_LH  = 6'd33;
   localparam logic [5:0] OP_LW  = 6'd35;
   localparam logic [5:0] OP_LBU = 6'd36;
   localparam logic [5:0] OP_LHU = 6'd37;
   localparam logic [5:0] OP_SB  = 6'd40;
   localparam logic [5:0] OP_SH  = 6'd41;
   localparam logic [5:0] OP_SW  = 6'd43;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

   stateT state, stateNext;

   logic [5:0] op;
   logic       isLoad, isStore, isMemOp, needHalf, needWord, aligned;
   logic       startAcc, misalignHit, ackHit, timeoutHit;

   logic              reqReg, weReg;
   logic [3:0]        beReg;
   logic [ADDR_W-1:0] addrReg;
   logic [31:0]       wdataReg;
   logic [5:0]        opReg;
   logic [1:0]        offReg;

   // Instruction fields not consumed by the MEM stage (rs, immediate).
   logic unusedInstrBits;
   assign unusedInstrBits = ^{ex_mem_instr[25:21], ex_mem_instr[15:0]};

   assign op = ex_mem_instr[31:26];

   // Byte lane holding the addressed byte; for 2-bit offsets 3-off == ~off.
   function automatic logic [1:0] laneOf(input logic [1:0] off);
      return BIG_ENDIAN ? ~off : off;
   endfunction

   // Selects the upper (1) or lower (0) half-word lane of the bus.
   function automatic logic halfOf(input logic [1:0] off);
      return BIG_ENDIAN ? ~off[1] : off[1];
   endfunction

   function automatic logic [3:0] byteEnable(input logic [5:0] opc, input logic [1:0] off);
      logic [3:0] be;
      case (opc)
         OP_SB:   be = 4'b0001 << laneOf(off);
         OP_SH:   be = halfOf(off) ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] storeData(input logic [5:0] opc, input logic [31:0] wd);
      logic [31:0] res;
      case (opc)
         OP_SB:   res = {4{wd[7:0]}};
         OP_SH:   res = {2{wd[15:0]}};
         default: res = wd;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] loadExtend(input logic [5:0] opc, input logic [1:0] off,
                                              input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      case (laneOf(off))
         2'd0:    b = rd[7:0];
         2'd1:    b = rd[15:8];
         2'd2:    b = rd[23:16];
         default: b = rd[31:24];
      endcase
      h = halfOf(off) ? rd[31:16] : rd[15:0];
      case (opc)
         OP_LB:   res = {{24{b[7]}}, b};
         OP_LBU:  res = {24'h000000, b};
         OP_LH:   res = {{16{h[15]}}, h};
         OP_LHU:  res = {16'h0000, h};
         default: res = rd;
      endcase
      return res;
   endfunction

   // Classify the EX/MEM instruction and check its natural alignment
   always_comb begin
      isLoad   = 1'b0;
      isStore  = 1'b0;
      needHalf = 1'b0;
      needWord = 1'b0;
      case (op)
         OP_LB, OP_LBU: isLoad = 1'b1;
         OP_LH, OP_LHU: begin isLoad  = 1'b1; needHalf = 1'b1; end
         OP_LW:         begin isLoad  = 1'b1; needWord = 1'b1; end
         OP_SB:         isStore = 1'b1;
         OP_SH:         begin isStore = 1'b1; needHalf = 1'b1; end
         OP_SW:         begin isStore = 1'b1; needWord = 1'b1; end
         default:       ;
      endcase
      isMemOp = ex_mem_valid && (isLoad || isStore);
      aligned = !(needHalf && ex_mem_addr[0]) && !(needWord && (ex_mem_addr[1:0] != 2'b00));
   end

   // Next-state logic plus the combinational stall seen by the pipeline
   always_comb begin
      stateNext   = state;
      startAcc    = 1'b0;
      misalignHit = 1'b0;
      ackHit      = 1'b0;
      mem_stall   = 1'b0;
      case (state)
         IDLE: begin
            if (isMemOp) begin
               if (aligned) begin
                  mem_stall = 1'b1;
                  startAcc  = 1'b1;
                  stateNext = BUSY;
               end else begin
                  misalignHit = 1'b1;
               end
            end
         end
         BUSY: begin
            mem_stall = 1'b1;
            if (dmem.dmem_ack) begin
               ackHit    = 1'b1;
               stateNext = DONE;
            end else if (timeoutHit) begin
               stateNext = DONE;
            end
         end
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
      if (rst) begin
         mem_stall = 1'b0;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Request registers, load result capture and the misalignment pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         reqReg       <= 1'b0;
         weReg        <= 1'b0;
         beReg        <= 4'b0000;
         addrReg      <= '0;
         wdataReg     <= 32'h0;
         opReg        <= 6'd0;
         offReg       <= 2'd0;
         load_valid   <= 1'b0;
         load_data    <= 32'h0;
         load_rt      <= 5'd0;
         misalign_exc <= 1'b0;
      end else begin
         misalign_exc <= misalignHit;
         load_valid   <= 1'b0;
         if (startAcc) begin
            reqReg   <= 1'b1;
            weReg    <= isStore;
            beReg    <= byteEnable(op, ex_mem_addr[1:0]);
            addrReg  <= {ex_mem_addr[ADDR_W-1:2], 2'b00};
            wdataReg <= storeData(op, ex_mem_wdata);
            load_rt  <= ex_mem_instr[20:16];
            opReg    <= op;
            offReg   <= ex_mem_addr[1:0];
         end
         if (ackHit) begin
            reqReg <= 1'b0;
            if (!weReg) begin
               load_data  <= loadExtend(opReg, offReg, dmem.dmem_rdata);
               load_valid <= 1'b1;
            end
         end else if (timeoutHit) begin
            reqReg <= 1'b0;
         end
      end
   end

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] toCnt;
   logic             timeoutPulse;

   // The cycle that would bring the count to TIMEOUT_CYCLES aborts; ack wins.
   assign timeoutHit = (state == BUSY) && !dmem.dmem_ack &&
                       (toCnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Count BUSY cycles spent waiting for ack; cleared when an access starts
   always_ff @(posedge clk) begin
      if (rst) begin
         toCnt        <= '0;
         timeoutPulse <= 1'b0;
      end else begin
         timeoutPulse <= timeoutHit;
         if (startAcc) begin
            toCnt <= '0;
         end else if ((state == BUSY) && !dmem.dmem_ack) begin
            toCnt <= toCnt + CNT_W'(1);
         end
      end
   end

   assign timeout_exc = timeoutPulse;
`else
   assign timeoutHit  = 1'b0;
   assign timeout_exc = 1'b0;
`endif

   assign dmem.dmem_req   = reqReg;
   assign dmem.dmem_we    = weReg;
   assign dmem.dmem_be    = beReg;
   assign dmem.dmem_addr  = addrReg;
   assign dmem.dmem_wdata = wdataReg;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a big-endian and a little-endian
// instance share the same stimulus and memory responses.
module tb_mem_access_unit;
   localparam int AW = 32;

   localparam logic [5:0] OP_LB  = 6'd32;
   localparam logic [5:0] OP_LH  = 6'd33;
   localparam logic [5:0] OP_LW  = 6'd35;
   localparam logic [5:0] OP_LBU = 6'd36;
   localparam logic [5:0] OP_LHU = 6'd37;
   localparam logic [5:0] OP_SB  = 6'd40;
   localparam logic [5:0] OP_SH  = 6'd41;
   localparam logic [5:0] OP_SW  = 6'd43;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [31:0]   instr;
   logic          valid;
   logic [AW-1:0] exAddr;
   logic [31:0]   exWdata;
   logic          ack;
   logic [31:0]   rdata;

   logic          stallBe, loadValidBe, misBe, toBe;
   logic [31:0]   loadDataBe;
   logic [4:0]    rtBe;
   logic          stallLe, loadValidLe, misLe, toLe;
   logic [31:0]   loadDataLe;
   logic [4:0]    rtLe;

   mem_access_unit_if #(.ADDR_W(AW)) busBe ();
   mem_access_unit_if #(.ADDR_W(AW)) busLe ();

   assign busBe.dmem_ack   = ack;
   assign busBe.dmem_rdata = rdata;
   assign busLe.dmem_ack   = ack;
   assign busLe.dmem_rdata = rdata;

   mem_access_unit #(.ADDR_W(AW), .BIG_ENDIAN(1'b1), .TIMEOUT_CYCLES(4)) dutBe (
      .clk(clk), .rst(rst),
      .ex_mem_instr(instr), .ex_mem_valid(valid), .ex_mem_addr(exAddr), .ex_mem_wdata(exWdata),
      .dmem(busBe),
      .mem_stall(stallBe), .load_valid(loadValidBe), .load_data(loadDataBe), .load_rt(rtBe),
      .misalign_exc(misBe), .timeout_exc(toBe)
   );

   mem_access_unit #(.ADDR_W(AW), .BIG_ENDIAN(1'b0), .TIMEOUT_CYCLES(4)) dutLe (
      .clk(clk), .rst(rst),
      .ex_mem_instr(instr), .ex_mem_valid(valid), .ex_mem_addr(exAddr), .ex_mem_wdata(exWdata),
      .dmem(busLe),
      .mem_stall(stallLe), .load_valid(loadValidLe), .load_data(loadDataLe), .load_rt(rtLe),
      .misalign_exc(misLe), .timeout_exc(toLe)
   );

   int checks = 0;
   int errors = 0;
   int reqCycles;
   int stallCycles;

   logic [3:0]    beSeenBe, beSeenLe;
   logic [31:0]   wdSeenBe;
   logic [AW-1:0] addrSeen;
   logic          weSeen;
   logic          toSeen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample 2 time units after the rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
      if (busBe.dmem_req) reqCycles++;
      if (stallBe) stallCycles++;
   endtask

   // Present an aligned access, ack it k cycles after the request rises,
   // and return with the unit in DONE.
   task automatic runAccess(input logic [5:0] op, input logic [4:0] rt, input logic [AW-1:0] addr,
                            input logic [31:0] wd, input int k, input logic [31:0] rd);
      instr   = {op, 5'd0, rt, 16'h1234};
      exAddr  = addr;
      exWdata = wd;
      valid   = 1'b1;
      #1;
      reqCycles   = busBe.dmem_req ? 1 : 0;
      stallCycles = stallBe ? 1 : 0;
      tick();
      beSeenBe = busBe.dmem_be;
      beSeenLe = busLe.dmem_be;
      wdSeenBe = busBe.dmem_wdata;
      addrSeen = busBe.dmem_addr;
      weSeen   = busBe.dmem_we;
      repeat (k) tick();
      ack   = 1'b1;
      rdata = rd;
      tick();
      ack = 1'b0;
   endtask

   task automatic endAccess();
      valid = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b1; valid = 1'b0; instr = 32'h0; exAddr = '0; exWdata = 32'h0;
      ack = 1'b0; rdata = 32'h0;
      repeat (3) tick();
      check("rst_req", busBe.dmem_req, 0);
      check("rst_we", busBe.dmem_we, 0);
      check("rst_be", busBe.dmem_be, 0);
      check("rst_addr", busBe.dmem_addr, 0);
      check("rst_wdata", busBe.dmem_wdata, 0);
      check("rst_lvalid", loadValidBe, 0);
      check("rst_ldata", loadDataBe, 0);
      check("rst_rt", rtBe, 0);
      check("rst_mis", misBe, 0);
      check("rst_to", toBe, 0);
      check("rst_stall", stallBe, 0);
      rst = 1'b0;
      tick();

      // lw, k=2
      runAccess(OP_LW, 5'd9, 32'h100, 32'h0, 2, 32'hDEADBEEF);
      check("lw_req_cycles", reqCycles, 3);
      check("lw_stall_cycles", stallCycles, 4);
      check("lw_be", beSeenBe, 4'b1111);
      check("lw_we", weSeen, 0);
      check("lw_addr", addrSeen, 32'h100);
      check("lw_req_dropped", busBe.dmem_req, 0);
      check("lw_done_stall", stallBe, 0);
      check("lw_lvalid", loadValidBe, 1);
      check("lw_data", loadDataBe, 32'hDEADBEEF);
      check("lw_rt", rtBe, 9);
      endAccess();
      check("lw_lvalid_pulse", loadValidBe, 0);

      // lb / lbu at offset 3
      runAccess(OP_LB, 5'd4, 32'h103, 32'h0, 0, 32'h12345680);
      check("lb_stall_min", stallCycles, 2);
      check("lb_be", beSeenBe, 4'b1111);
      check("lb_data_be", loadDataBe, 32'hFFFFFF80);
      check("lb_data_le", loadDataLe, 32'h00000012);
      endAccess();
      runAccess(OP_LBU, 5'd5, 32'h103, 32'h0, 1, 32'h12345680);
      check("lbu_data_be", loadDataBe, 32'h00000080);
      check("lbu_lvalid", loadValidBe, 1);
      endAccess();

      // half-word loads
      runAccess(OP_LH, 5'd6, 32'h102, 32'h0, 0, 32'h12348765);
      check("lh_data_be", loadDataBe, 32'hFFFF8765);
      check("lh_data_le", loadDataLe, 32'h00001234);
      endAccess();
      runAccess(OP_LHU, 5'd7, 32'h100, 32'h0, 0, 32'h87651234);
      check("lhu_data_be", loadDataBe, 32'h00008765);
      check("lhu_data_le", loadDataLe, 32'h00001234);
      endAccess();

      // stores
      runAccess(OP_SH, 5'd8, 32'h202, 32'h0000ABCD, 1, 32'h0);
      check("sh_be_be", beSeenBe, 4'b0011);
      check("sh_be_le", beSeenLe, 4'b1100);
      check("sh_wdata", wdSeenBe, 32'hABCDABCD);
      check("sh_addr", addrSeen, 32'h200);
      check("sh_we", weSeen, 1);
      check("sh_no_lvalid", loadValidBe, 0);
      endAccess();
      runAccess(OP_SB, 5'd8, 32'h201, 32'h123456A5, 0, 32'h0);
      check("sb_be_be", beSeenBe, 4'b0100);
      check("sb_be_le", beSeenLe, 4'b0010);
      check("sb_wdata", wdSeenBe, 32'hA5A5A5A5);
      endAccess();
      runAccess(OP_SW, 5'd8, 32'h300, 32'hCAFEF00D, 0, 32'h0);
      check("sw_be", beSeenBe, 4'b1111);
      check("sw_wdata", wdSeenBe, 32'hCAFEF00D);
      endAccess();

      // misaligned accesses
      instr = {OP_LW, 5'd0, 5'd3, 16'h0}; exAddr = 32'h102; valid = 1'b1;
      #1;
      check("mis_lw_stall", stallBe, 0);
      tick();
      check("mis_lw_exc", misBe, 1);
      check("mis_lw_req", busBe.dmem_req, 0);
      valid = 1'b0;
      tick();
      check("mis_lw_pulse", misBe, 0);
      instr = {OP_SH, 5'd0, 5'd3, 16'h0}; exAddr = 32'h203; valid = 1'b1;
      tick();
      check("mis_sh_exc", misLe, 1);
      check("mis_sh_req", busLe.dmem_req, 0);
      valid = 1'b0;
      tick();

      // non-memory op and bubble
      instr = {6'd0, 5'd1, 5'd2, 16'h0}; exAddr = 32'h100; valid = 1'b1;
      #1;
      check("alu_stall", stallBe, 0);
      tick();
      check("alu_req", busBe.dmem_req, 0);
      instr = {OP_LW, 5'd0, 5'd2, 16'h0}; valid = 1'b0;
      #1;
      check("bubble_stall", stallBe, 0);
      tick();
      check("bubble_req", busBe.dmem_req, 0);

      // reset during BUSY, late ack ignored
      instr = {OP_LW, 5'd0, 5'd10, 16'h0}; exAddr = 32'h400; valid = 1'b1;
      tick();
      check("rb_req_busy", busBe.dmem_req, 1);
      rst = 1'b1;
      tick();
      check("rb_req_drop", busBe.dmem_req, 0);
      rst = 1'b0; valid = 1'b0; ack = 1'b1; rdata = 32'h55AA55AA;
      tick();
      ack = 1'b0;
      check("rb_lvalid", loadValidBe, 0);
      check("rb_ldata", loadDataBe, 0);
      check("rb_stall", stallBe, 0);
      tick();
      check("rb_lvalid2", loadValidBe, 0);
      check("rb_req_idle", busBe.dmem_req, 0);

`ifdef MEM_TIMEOUT_EN
      instr = {OP_SW, 5'd0, 5'd3, 16'h0}; exAddr = 32'h500; exWdata = 32'h1; valid = 1'b1;
      reqCycles = 0; stallCycles = 0; toSeen = 1'b0;
      for (int c = 0; c < 10 && !toSeen; c++) begin
         tick();
         toSeen = toBe;
      end
      check("to_seen", toSeen, 1);
      check("to_req_cycles", reqCycles, 4);
      check("to_req_drop", busBe.dmem_req, 0);
      check("to_done_stall", stallBe, 0);
      check("to_no_lvalid", loadValidBe, 0);
      valid = 1'b0;
      tick();
      check("to_pulse", toBe, 0);
      check("to_idle_req", busBe.dmem_req, 0);
`else
      check("to_tied_low", toBe, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sequential MEM-stage load/store engine for the 48-instruction MIPS pipeline.
- Decodes the EX/MEM instruction and drives a request/acknowledge data-memory interface with variable latency.
- Generates byte enables and load extension, stalls the pipeline until the access completes, and flags misaligned or timed-out accesses.
- Supersedes the purely combinational MEM read/write-enable decode. Adds a configurable endianness mode and address width.

Parameters:
- ADDR_W, 32: data address width (>=3).
- BIG_ENDIAN, 1: 1 means byte 0 sits on lane [31:24] (MIPS default); 0 means byte 0 sits on lane [7:0].
- TIMEOUT_CYCLES, 255: maximum cycles in BUSY without ack (used only with MEM_TIMEOUT_EN); counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- ex_mem_instr  in  32  instruction in EX/MEM; op=[31:26].
- ex_mem_valid  in  1  instruction is valid (not a bubble).
- ex_mem_addr  in  ADDR_W  effective address from the ALU.
- ex_mem_wdata  in  32  rt store data.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1=store, 0=load.
- dmem_be  out  4  byte enables.
- dmem_addr  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2],2'b00}.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_rdata  in  32  read word.
- dmem_ack  in  1  access complete.
- mem_stall  out  1  freeze IF..EX/MEM.
- load_valid  out  1  load result valid (one-cycle pulse).
- load_data  out  32  extended load result.
- load_rt  out  5  destination register, instr[20:16].
- misalign_exc  out  1  alignment fault (one-cycle pulse).
- timeout_exc  out  1  timeout fault (one-cycle pulse, MEM_TIMEOUT_EN only; tied 0 otherwise).

Behaviour:

Reset:
- Synchronous, active-high; the FSM enters IDLE.
- dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, load_valid, load_data, load_rt, misalign_exc and timeout_exc all reset to 0.
- mem_stall is 0 at reset.
- rst asserted mid-access drops dmem_req on the next edge. A late dmem_ack arriving in IDLE is ignored.

Decode (op):
- Loads: lb=32, lh=33, lw=35, lbu=36, lhu=37.
- Stores: sb=40, sh=41, sw=43.
- Any other op, or ex_mem_valid=0, is a non-memory instruction: no request, mem_stall=0.

Alignment (checked in IDLE):
- Half-word ops require addr[0]=0.
- Word ops require addr[1:0]=0.
- On misalignment: misalign_exc pulses at the next edge, no request is issued, mem_stall=0, and the FSM stays in IDLE.

FSM:
- IDLE: for an aligned memory op, mem_stall=1 combinationally. Register dmem_req=1, we, be, addr and wdata, and load_rt; go to BUSY.
- BUSY: mem_stall=1. The registered request outputs are held stable until dmem_ack is sampled 1. On ack, drop dmem_req and go to DONE; for a load, also capture the extended dmem_rdata into load_data.
- DONE: mem_stall=0. load_valid=1 for loads only. Always returns to IDLE. A new op is never started from DONE.

Latency:
- Op presented at cycle t; dmem_req is high from t+1.
- Ack arrives at t+1+k (k>=0); DONE occurs at t+2+k.
- Minimum stall is 2 cycles.

Lanes:
- Lane index: lane = BIG_ENDIAN ? 3-addr[1:0] : addr[1:0].
- Half-word lanes: half = BIG_ENDIAN ? ~addr[1] : addr[1].
- sb: be=one-hot(lane); wdata = byte replicated x4.
- sh: be=4'b0011 or 4'b1100 selected by half; wdata = half replicated x2.
- sw: be=4'b1111.
- Loads: be=4'b1111, we=0.
- lb/lh sign-extend; lbu/lhu zero-extend.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- When defined: a counter clears on entry to BUSY and increments each BUSY cycle without ack. When the count reaches TIMEOUT_CYCLES, the unit drops dmem_req, pulses timeout_exc, and goes to DONE with load_valid forced to 0.
- Ack takes priority over timeout when both occur in the same cycle.
- When undefined: no counter, BUSY waits indefinitely, and timeout_exc is constant 0.

Test Plan:
- lw, addr=0x100, ack at k=2, rdata=0xDEADBEEF → dmem_req high 3 cycles, mem_stall high 4 cycles, then load_valid=1, load_data=0xDEADBEEF, load_rt=instr[20:16].
- lb addr=0x103 with BIG_ENDIAN=1 and rdata=0x1234_5680 → load_data=0xFFFFFF80. The same access with lbu → 0x00000080.
- sh addr=0x202, wdata=0x0000ABCD, BIG_ENDIAN=1 → dmem_be=4'b0011, dmem_wdata=0xABCDABCD, dmem_addr=0x200. With BIG_ENDIAN=0 → be=4'b1100.
- lw addr=0x102 → misalign_exc pulses for 1 cycle, dmem_req stays 0, mem_stall=0.
- rst asserted in BUSY, then dmem_ack arriving 1 cycle later → IDLE, outputs 0, no load_valid.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, sw with no ack → timeout_exc pulses, dmem_req drops, and the FSM passes through DONE to IDLE.
